// File: rtl/icache_pkg.sv
// Shared instruction-cache refill definitions: geometry constants, fill FSM states
// and the bank address mapping used by the data blockrams and the tag array.
package icache_pkg;

    localparam int SET_W  = 9;
    localparam int WAY_W  = 2;
    localparam int QW_W   = 128;
    localparam int NQ     = 4;
    localparam int ADDR_W = SET_W + WAY_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } fill_state_t;

    // Every quarter bank holds one beat of each line at the same {set,way} slot.
    function automatic logic [ADDR_W-1:0] bank_addr(input logic [SET_W-1:0] set,
                                                     input logic [WAY_W-1:0] way);
        return {set, way};
    endfunction

endpackage

// File: rtl/icache_fill_writer.sv
// Refill writer: takes one miss-fill request plus four memory beats and streams each
// beat into its quarter bank through a registered shared write port.
module icache_fill_writer
    import icache_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [SET_W-1:0]  req_set,
    input  logic [WAY_W-1:0]  req_way,
    input  logic [1:0]        req_first_qw,
    input  logic              beat_valid,
    output logic              beat_ready,
    input  logic [QW_W-1:0]   beat_data,
    input  logic              fill_abort,
    output logic [NQ-1:0]     bram_wr_en,
    output logic [ADDR_W-1:0] bram_wr_addr,
    output logic [QW_W-1:0]   bram_wr_data,
    output logic              busy,
    output logic              fill_done,
    output logic [SET_W-1:0]  fill_set,
    output logic [WAY_W-1:0]  fill_way
);

    fill_state_t       state_q, state_d;
    logic [SET_W-1:0]  set_q, set_d;
    logic [WAY_W-1:0]  way_q, way_d;
    logic [1:0]        qptr_q, qptr_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [NQ-1:0]     wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [QW_W-1:0]   wr_data_q, wr_data_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;

    // Abort must stop the beat handshake in the same cycle, so the ready is not registered.
    assign beat_ready = (state_q == FILL) && !fill_abort;
    assign req_ready  = (state_q == IDLE) && !rst;

    always_comb begin
        state_d   = state_q;
        set_d     = set_q;
        way_d     = way_q;
        qptr_d    = qptr_q;
        cnt_d     = cnt_q;
        wr_en_d   = '0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        done_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d = FILL;
                    set_d   = req_set;
                    way_d   = req_way;
                    qptr_d  = req_first_qw;
                    cnt_d   = 3'd0;
                end
            end
            FILL: begin
                if (fill_abort) begin
                    state_d = IDLE;
                end else if (beat_valid) begin
                    wr_en_d   = NQ'(1) << qptr_q;
                    wr_addr_d = bank_addr(set_q, way_q);
                    wr_data_d = beat_data;
                    qptr_d    = qptr_q + 2'd1;
                    cnt_d     = cnt_q + 3'd1;
                    if (cnt_q == 3'd3) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                state_d = fill_abort ? IDLE : DONE;
                done_d  = !fill_abort;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            set_q     <= '0;
            way_q     <= '0;
            qptr_q    <= '0;
            cnt_q     <= '0;
            wr_en_q   <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            set_q     <= set_d;
            way_q     <= way_d;
            qptr_q    <= qptr_d;
            cnt_q     <= cnt_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    assign bram_wr_en   = wr_en_q;
    assign bram_wr_addr = wr_addr_q;
    assign bram_wr_data = wr_data_q;
    assign busy         = busy_q;
    assign fill_done    = done_q;
    assign fill_set     = set_q;
    assign fill_way     = way_q;

endmodule

// File: tb/tb_icache_fill_writer.sv
// Bench for icache_fill_writer: directed and random fills checked against a timeline
// model of expected bank writes and done pulses, plus a final bank readback.
module tb_icache_fill_writer;
    import icache_pkg::*;

    localparam int MAXC = 4096;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [SET_W-1:0]  req_set = '0;
    logic [WAY_W-1:0]  req_way = '0;
    logic [1:0]        req_first_qw = '0;
    logic              beat_valid = 1'b0;
    logic              beat_ready;
    logic [QW_W-1:0]   beat_data = '0;
    logic              fill_abort = 1'b0;
    logic [NQ-1:0]     bram_wr_en;
    logic [ADDR_W-1:0] bram_wr_addr;
    logic [QW_W-1:0]   bram_wr_data;
    logic              busy;
    logic              fill_done;
    logic [SET_W-1:0]  fill_set;
    logic [WAY_W-1:0]  fill_way;

    always #5 clk = ~clk;

    icache_fill_writer dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_set      (req_set),
        .req_way      (req_way),
        .req_first_qw (req_first_qw),
        .beat_valid   (beat_valid),
        .beat_ready   (beat_ready),
        .beat_data    (beat_data),
        .fill_abort   (fill_abort),
        .bram_wr_en   (bram_wr_en),
        .bram_wr_addr (bram_wr_addr),
        .bram_wr_data (bram_wr_data),
        .busy         (busy),
        .fill_done    (fill_done),
        .fill_set     (fill_set),
        .fill_way     (fill_way)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Timeline model: what each future cycle should show on the write port and done pulse.
    logic [3:0]        exp_en   [MAXC];
    int                exp_q    [MAXC];
    logic [ADDR_W-1:0] exp_addr [MAXC];
    logic [QW_W-1:0]   exp_data [MAXC];
    bit                exp_done [MAXC];
    logic [SET_W-1:0]  exp_fset [MAXC];
    logic [WAY_W-1:0]  exp_fway [MAXC];

    bit                open_fill   = 1'b0;
    int                next_accept = 0;
    int                beats_taken = 0;
    int                drain_cyc   = -10;
    logic [1:0]        m_first;
    logic [SET_W-1:0]  m_set;
    logic [WAY_W-1:0]  m_way;

    logic [QW_W-1:0]   ref_mem  [int];
    logic [QW_W-1:0]   bank_mem [4][2048];

    // Behavioural quarter banks, written from the DUT write port like the real blockrams.
    always @(posedge clk) begin
        for (int q = 0; q < 4; q++) begin
            if (bram_wr_en[q]) bank_mem[q][bram_wr_addr] <= bram_wr_data;
        end
    end

    task automatic checkOutput(input string tag, input logic [QW_W-1:0] obs, input logic [QW_W-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic clearFuture();
        for (int k = cyc; k < cyc + 4 && k < MAXC; k++) begin
            exp_en[k]   = '0;
            exp_done[k] = 1'b0;
        end
    endtask

    task automatic applyStimulus(input bit rv, input logic [SET_W-1:0] s, input logic [WAY_W-1:0] w,
                                 input logic [1:0] fq, input bit bv, input logic [QW_W-1:0] d, input bit ab);
        int q;
        req_valid    = rv;
        req_set      = s;
        req_way      = w;
        req_first_qw = fq;
        beat_valid   = bv;
        beat_data    = d;
        fill_abort   = ab;
        #1;
        checkOutput("wr_en", bram_wr_en, exp_en[cyc]);
        if (exp_en[cyc] != 0) begin
            checkOutput("wr_addr", bram_wr_addr, exp_addr[cyc]);
            checkOutput("wr_data", bram_wr_data, exp_data[cyc]);
            ref_mem[exp_q[cyc] * 2048 + int'(exp_addr[cyc])] = exp_data[cyc];
        end
        checkOutput("fill_done", fill_done, exp_done[cyc]);
        if (exp_done[cyc]) begin
            checkOutput("fill_set", fill_set, exp_fset[cyc]);
            checkOutput("fill_way", fill_way, exp_fway[cyc]);
        end
        checkOutput("req_ready", req_ready, !open_fill && cyc >= next_accept);
        checkOutput("beat_ready", beat_ready, open_fill && !ab);
        checkOutput("busy", busy, open_fill || cyc < next_accept);

        if (open_fill) begin
            if (ab) begin
                open_fill   = 1'b0;
                next_accept = cyc + 1;
            end else if (bv) begin
                q = (int'(m_first) + beats_taken) % 4;
                exp_en[cyc+1]   = 4'(1 << q);
                exp_q[cyc+1]    = q;
                exp_addr[cyc+1] = {m_set, m_way};
                exp_data[cyc+1] = d;
                beats_taken++;
                if (beats_taken == 4) begin
                    open_fill       = 1'b0;
                    drain_cyc       = cyc + 1;
                    exp_done[cyc+2] = 1'b1;
                    exp_fset[cyc+2] = m_set;
                    exp_fway[cyc+2] = m_way;
                    next_accept     = cyc + 3;
                end
            end
        end else if (cyc == drain_cyc && ab) begin
            exp_done[cyc+1] = 1'b0;
            next_accept     = cyc + 1;
        end else if (rv && cyc >= next_accept) begin
            open_fill   = 1'b1;
            beats_taken = 0;
            m_first     = fq;
            m_set       = s;
            m_way       = w;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic applyReset();
        req_valid  = 1'b0;
        beat_valid = 1'b0;
        fill_abort = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rst_wr_en", bram_wr_en, '0);
        checkOutput("rst_wr_addr", bram_wr_addr, '0);
        checkOutput("rst_wr_data", bram_wr_data, '0);
        checkOutput("rst_fill_done", fill_done, '0);
        checkOutput("rst_busy", busy, '0);
        checkOutput("rst_beat_ready", beat_ready, '0);
        checkOutput("rst_req_ready", req_ready, '0);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("rel_req_ready", req_ready, 1'b1);
        checkOutput("rel_busy", busy, 1'b0);
        open_fill   = 1'b0;
        drain_cyc   = -10;
        next_accept = cyc;
        clearFuture();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, '0, '0, '0, 0, '0, 0);
    endtask

    task automatic sendReq(input logic [SET_W-1:0] s, input logic [WAY_W-1:0] w, input logic [1:0] fq);
        applyStimulus(1, s, w, fq, 0, '0, 0);
    endtask

    task automatic sendBeat(input logic [QW_W-1:0] d);
        applyStimulus(0, '0, '0, '0, 1, d, 0);
    endtask

    task automatic fullFill(input logic [SET_W-1:0] s, input logic [WAY_W-1:0] w, input logic [1:0] fq);
        sendReq(s, w, fq);
        for (int i = 0; i < 4; i++) sendBeat({4{$urandom}});
        idleCycles(3);
    endtask

    initial begin
        bit gap_pat [7] = '{1, 0, 0, 1, 0, 1, 1};
        for (int k = 0; k < MAXC; k++) begin
            exp_en[k]   = '0;
            exp_q[k]    = 0;
            exp_addr[k] = '0;
            exp_data[k] = '0;
            exp_done[k] = 1'b0;
            exp_fset[k] = '0;
            exp_fway[k] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        applyReset();
        idleCycles(1);

        sendReq(9'h1A5, 2'd2, 2'd0);
        for (int i = 0; i < 4; i++) sendBeat({32'hD0D0_0000 + i, 96'h0});
        idleCycles(4);

        sendReq(9'h033, 2'd1, 2'd3);
        sendBeat({4{32'hAAAA_AAAA}});
        sendBeat({4{32'hBBBB_BBBB}});
        sendBeat({4{32'hCCCC_CCCC}});
        sendBeat({4{32'hDDDD_DDDD}});
        idleCycles(3);

        sendReq(9'h100, 2'd3, 2'd1);
        for (int i = 0; i < 7; i++) applyStimulus(0, '0, '0, '0, gap_pat[i], {4{$urandom}}, 0);
        idleCycles(4);

        sendReq(9'h055, 2'd0, 2'd2);
        sendBeat({4{$urandom}});
        sendBeat({4{$urandom}});
        applyStimulus(0, '0, '0, '0, 1, {4{$urandom}}, 1);
        sendBeat({4{$urandom}});
        sendBeat({4{$urandom}});
        fullFill(9'h055, 2'd0, 2'd2);

        sendReq(9'h0F0, 2'd1, 2'd1);
        for (int i = 0; i < 3; i++) sendBeat({4{$urandom}});
        applyReset();
        idleCycles(2);
        fullFill(9'h0F0, 2'd1, 2'd1);

        sendReq(9'h1FF, 2'd3, 2'd0);
        for (int i = 0; i < 4; i++) sendBeat({4{$urandom}});
        applyStimulus(0, '0, '0, '0, 1, {4{$urandom}}, 1);
        idleCycles(3);

        sendReq(9'h002, 2'd2, 2'd3);
        for (int i = 0; i < 4; i++) sendBeat({4{$urandom}});
        idleCycles(1);
        applyStimulus(1, 9'h003, 2'd1, 2'd2, 1, {4{$urandom}}, 1);
        fullFill(9'h003, 2'd1, 2'd2);

        for (int i = 0; i < 700; i++) begin
            if ($urandom_range(0, 250) == 0) begin
                applyReset();
            end else begin
                applyStimulus($urandom_range(0, 3) == 0, SET_W'($urandom), WAY_W'($urandom),
                              2'($urandom), $urandom_range(0, 3) != 0, {4{$urandom}},
                              $urandom_range(0, 30) == 0);
            end
        end
        idleCycles(4);

        foreach (ref_mem[k]) begin
            checkOutput("readback", bank_mem[k / 2048][k % 2048], ref_mem[k]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
